// File: rtl/sw_uart_seq_bridge_if.sv
// Bus bundle between the UART-polling bridge and its neighbours: the Avalon-MM master port
// toward the RS232 UART and the request/result handshake toward the Smith-Waterman core.
interface sw_uart_seq_bridge_if #(
   parameter int MAX_REF_LEN  = 128,
   parameter int MAX_READ_LEN = 128,
   parameter int SCORE_W      = 10
);
   logic [4:0]                  avm_address;
   logic                        avm_read;
   logic [31:0]                 avm_readdata;
   logic                        avm_write;
   logic [31:0]                 avm_writedata;
   logic                        avm_waitrequest;

   logic                        sw_valid;
   logic                        sw_ready;
   logic [2*MAX_REF_LEN-1:0]    sw_ref_seq;
   logic [2*MAX_READ_LEN-1:0]   sw_read_seq;
   logic [7:0]                  sw_ref_len;
   logic [7:0]                  sw_read_len;
   logic                        sw_res_valid;
   logic                        sw_res_ready;
   logic [SCORE_W-1:0]          sw_score;
   logic [15:0]                 sw_col;
   logic [15:0]                 sw_row;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_waitrequest,
      output sw_valid, sw_ref_seq, sw_read_seq, sw_ref_len, sw_read_len, sw_res_ready,
      input  sw_ready, sw_res_valid, sw_score, sw_col, sw_row
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_waitrequest,
      input  sw_valid, sw_ref_seq, sw_read_seq, sw_ref_len, sw_read_len, sw_res_ready,
      output sw_ready, sw_res_valid, sw_score, sw_col, sw_row
   );
endinterface

// File: rtl/sw_uart_seq_bridge.sv
// Avalon-MM master that gathers a sequence frame from the RS232 UART, hands it to the
// Smith-Waterman core, and returns a 6-byte result (all 0xFF if the core hangs).
module sw_uart_seq_bridge #(
   parameter int MAX_REF_LEN  = 128,
   parameter int MAX_READ_LEN = 128,
   parameter int SCORE_W      = 10,
   parameter int TIMEOUT_CYC  = 65535
) (
   input  logic                 avm_clk,
   input  logic                 avm_rst,
   sw_uart_seq_bridge_if.master bus,
   output logic [15:0]          frame_cnt
);
   localparam int REF_W  = 2 * MAX_REF_LEN;
   localparam int RD_W   = 2 * MAX_READ_LEN;
   localparam int REF_CW = $clog2(MAX_REF_LEN + 3);
   localparam int RD_CW  = $clog2(MAX_READ_LEN + 3);
   localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      MAX_REF_B   = 8'(MAX_REF_LEN);
   localparam logic [7:0]      MAX_RD_B    = 8'(MAX_READ_LEN);
   localparam logic [4:0]      ADDR_RX     = 5'd0;
   localparam logic [4:0]      ADDR_TX     = 5'd4;
   localparam logic [4:0]      ADDR_STATUS = 5'd8;
   localparam logic [47:0]     ERR_FRAME   = 48'hFFFF_FFFF_FFFF;

   if (MAX_REF_LEN < 1 || MAX_REF_LEN > 255 || MAX_READ_LEN < 1 || MAX_READ_LEN > 255 ||
       SCORE_W < 1 || SCORE_W > 16 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("sw_uart_seq_bridge: illegal parameter value");
   end

   typedef enum logic [2:0] {
      ST_QUERY_RX  = 3'd0,
      ST_READ_RX   = 3'd1,
      ST_CORE_REQ  = 3'd2,
      ST_CORE_WAIT = 3'd3,
      ST_QUERY_TX  = 3'd4,
      ST_WRITE_TX  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PH_REF_LEN  = 2'd0,
      PH_READ_LEN = 2'd1,
      PH_REF      = 2'd2,
      PH_READ     = 2'd3
   } phase_t;

   function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
      return ((len == 8'd0) || (len > max_len)) ? max_len : len;
   endfunction

   state_t            state_r,         state_nxt_s;
   phase_t            phase_r,         phase_nxt_s;
   logic [4:0]        avm_address_r,   avm_address_nxt_s;
   logic              avm_read_r,      avm_read_nxt_s;
   logic              avm_write_r,     avm_write_nxt_s;
   logic [31:0]       avm_writedata_r, avm_writedata_nxt_s;
   logic              sw_valid_r,      sw_valid_nxt_s;
   logic              sw_res_ready_r,  sw_res_ready_nxt_s;
   logic [REF_W-1:0]  ref_seq_r,       ref_seq_nxt_s;
   logic [RD_W-1:0]   read_seq_r,      read_seq_nxt_s;
   logic [7:0]        ref_len_r,       ref_len_nxt_s;
   logic [7:0]        read_len_r,      read_len_nxt_s;
   logic [7:0]        ref_len_pend_r,  ref_len_pend_nxt_s;
   logic [REF_CW-1:0] ref_rem_r,       ref_rem_nxt_s;
   logic [RD_CW-1:0]  read_rem_r,      read_rem_nxt_s;
   logic [WD_W-1:0]   wd_r,            wd_nxt_s;
   logic [47:0]       tx_frame_r,      tx_frame_nxt_s;
   logic [2:0]        tx_idx_r,        tx_idx_nxt_s;
   logic [15:0]       frame_cnt_r,     frame_cnt_nxt_s;

   logic              acc_done_s;
   logic [7:0]        rx_byte_s;
   logic [23:0]       rd_unused_s;
   logic [15:0]       score_ext_s;
   logic              ref_lt4_s,  ref_last_s;
   logic              read_lt4_s, read_last_s;
   logic [3:0]        ref_sh_s,   read_sh_s;
   logic [REF_W-1:0]  ref_shift_s;
   logic [RD_W-1:0]   read_shift_s;

   assign acc_done_s  = ~bus.avm_waitrequest;
   assign rx_byte_s   = bus.avm_readdata[7:0];
   assign rd_unused_s = bus.avm_readdata[31:8];
   assign score_ext_s = 16'(bus.sw_score);

   // A short final byte keeps only its high-order bases; its low-order pad bits are dropped.
   assign ref_lt4_s    = (ref_rem_r < REF_CW'(3'd4));
   assign ref_last_s   = (ref_rem_r <= REF_CW'(3'd4));
   assign ref_sh_s     = ref_lt4_s ? {1'b0, ref_rem_r[1:0], 1'b0} : 4'd8;
   assign ref_shift_s  = (ref_seq_r << ref_sh_s) | REF_W'(rx_byte_s >> (4'd8 - ref_sh_s));
   assign read_lt4_s   = (read_rem_r < RD_CW'(3'd4));
   assign read_last_s  = (read_rem_r <= RD_CW'(3'd4));
   assign read_sh_s    = read_lt4_s ? {1'b0, read_rem_r[1:0], 1'b0} : 4'd8;
   assign read_shift_s = (read_seq_r << read_sh_s) | RD_W'(rx_byte_s >> (4'd8 - read_sh_s));

   // FSM state register
   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         state_r <= ST_QUERY_RX;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, next-output and datapath update logic
   always_comb begin
      state_nxt_s         = state_r;
      phase_nxt_s         = phase_r;
      avm_address_nxt_s   = avm_address_r;
      avm_read_nxt_s      = avm_read_r;
      avm_write_nxt_s     = avm_write_r;
      avm_writedata_nxt_s = avm_writedata_r;
      sw_valid_nxt_s      = sw_valid_r;
      sw_res_ready_nxt_s  = sw_res_ready_r;
      ref_seq_nxt_s       = ref_seq_r;
      read_seq_nxt_s      = read_seq_r;
      ref_len_nxt_s       = ref_len_r;
      read_len_nxt_s      = read_len_r;
      ref_len_pend_nxt_s  = ref_len_pend_r;
      ref_rem_nxt_s       = ref_rem_r;
      read_rem_nxt_s      = read_rem_r;
      wd_nxt_s            = wd_r;
      tx_frame_nxt_s      = tx_frame_r;
      tx_idx_nxt_s        = tx_idx_r;
      frame_cnt_nxt_s     = frame_cnt_r;

      case (state_r)
         ST_QUERY_RX: begin
            if (acc_done_s && bus.avm_readdata[7]) begin
               state_nxt_s       = ST_READ_RX;
               avm_address_nxt_s = ADDR_RX;
            end else begin
               state_nxt_s = ST_QUERY_RX;
            end
         end

         ST_READ_RX: begin
            if (acc_done_s) begin
               state_nxt_s       = ST_QUERY_RX;
               avm_address_nxt_s = ADDR_STATUS;
               case (phase_r)
                  PH_REF_LEN: begin
                     ref_len_pend_nxt_s = clamp_len(rx_byte_s, MAX_REF_B);
                     phase_nxt_s        = PH_READ_LEN;
                  end
                  PH_READ_LEN: begin
                     ref_len_nxt_s  = ref_len_pend_r;
                     read_len_nxt_s = clamp_len(rx_byte_s, MAX_RD_B);
                     ref_rem_nxt_s  = REF_CW'(ref_len_pend_r);
                     read_rem_nxt_s = RD_CW'(clamp_len(rx_byte_s, MAX_RD_B));
                     ref_seq_nxt_s  = {REF_W{1'b0}};
                     read_seq_nxt_s = {RD_W{1'b0}};
                     phase_nxt_s    = PH_REF;
                  end
                  PH_REF: begin
                     ref_seq_nxt_s = ref_shift_s;
                     ref_rem_nxt_s = ref_lt4_s ? {REF_CW{1'b0}} : (ref_rem_r - REF_CW'(3'd4));
                     if (ref_last_s) begin
                        phase_nxt_s = PH_READ;
                     end else begin
                        phase_nxt_s = PH_REF;
                     end
                  end
                  PH_READ: begin
                     read_seq_nxt_s = read_shift_s;
                     read_rem_nxt_s = read_lt4_s ? {RD_CW{1'b0}} : (read_rem_r - RD_CW'(3'd4));
                     if (read_last_s) begin
                        phase_nxt_s       = PH_REF_LEN;
                        state_nxt_s       = ST_CORE_REQ;
                        avm_read_nxt_s    = 1'b0;
                        sw_valid_nxt_s    = 1'b1;
                     end else begin
                        phase_nxt_s = PH_READ;
                     end
                  end
                  default: begin
                     phase_nxt_s = PH_REF_LEN;
                  end
               endcase
            end else begin
               state_nxt_s = ST_READ_RX;
            end
         end

         ST_CORE_REQ: begin
            if (sw_valid_r && bus.sw_ready) begin
               state_nxt_s        = ST_CORE_WAIT;
               sw_valid_nxt_s     = 1'b0;
               sw_res_ready_nxt_s = 1'b1;
               wd_nxt_s           = {WD_W{1'b0}};
            end else begin
               state_nxt_s = ST_CORE_REQ;
            end
         end

         // A real result beats a watchdog expiry landing in the same cycle.
         ST_CORE_WAIT: begin
            if (bus.sw_res_valid || (wd_r == WD_LAST)) begin
               tx_frame_nxt_s     = bus.sw_res_valid ? {score_ext_s, bus.sw_col, bus.sw_row}
                                                     : ERR_FRAME;
               state_nxt_s        = ST_QUERY_TX;
               sw_res_ready_nxt_s = 1'b0;
               avm_read_nxt_s     = 1'b1;
               avm_address_nxt_s  = ADDR_STATUS;
               tx_idx_nxt_s       = 3'd0;
            end else begin
               wd_nxt_s = wd_r + WD_W'(1'b1);
            end
         end

         ST_QUERY_TX: begin
            if (acc_done_s && bus.avm_readdata[6]) begin
               state_nxt_s         = ST_WRITE_TX;
               avm_address_nxt_s   = ADDR_TX;
               avm_read_nxt_s      = 1'b0;
               avm_write_nxt_s     = 1'b1;
               avm_writedata_nxt_s = {24'h00_0000, tx_frame_r[47:40]};
            end else begin
               state_nxt_s = ST_QUERY_TX;
            end
         end

         ST_WRITE_TX: begin
            if (acc_done_s) begin
               avm_address_nxt_s   = ADDR_STATUS;
               avm_read_nxt_s      = 1'b1;
               avm_write_nxt_s     = 1'b0;
               avm_writedata_nxt_s = 32'h0000_0000;
               tx_frame_nxt_s      = {tx_frame_r[39:0], 8'h00};
               if (tx_idx_r == 3'd5) begin
                  state_nxt_s        = ST_QUERY_RX;
                  tx_idx_nxt_s       = 3'd0;
                  frame_cnt_nxt_s    = frame_cnt_r + 16'd1;
                  ref_len_nxt_s      = 8'd0;
                  read_len_nxt_s     = 8'd0;
                  ref_len_pend_nxt_s = 8'd0;
               end else begin
                  state_nxt_s  = ST_QUERY_TX;
                  tx_idx_nxt_s = tx_idx_r + 3'd1;
               end
            end else begin
               state_nxt_s = ST_WRITE_TX;
            end
         end

         default: begin
            state_nxt_s         = ST_QUERY_RX;
            phase_nxt_s         = PH_REF_LEN;
            avm_address_nxt_s   = ADDR_STATUS;
            avm_read_nxt_s      = 1'b1;
            avm_write_nxt_s     = 1'b0;
            avm_writedata_nxt_s = 32'h0000_0000;
            sw_valid_nxt_s      = 1'b0;
            sw_res_ready_nxt_s  = 1'b0;
         end
      endcase
   end

   // Datapath and registered output update
   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         phase_r         <= PH_REF_LEN;
         avm_address_r   <= ADDR_STATUS;
         avm_read_r      <= 1'b1;
         avm_write_r     <= 1'b0;
         avm_writedata_r <= 32'h0000_0000;
         sw_valid_r      <= 1'b0;
         sw_res_ready_r  <= 1'b0;
         ref_seq_r       <= {REF_W{1'b0}};
         read_seq_r      <= {RD_W{1'b0}};
         ref_len_r       <= 8'd0;
         read_len_r      <= 8'd0;
         ref_len_pend_r  <= 8'd0;
         ref_rem_r       <= {REF_CW{1'b0}};
         read_rem_r      <= {RD_CW{1'b0}};
         wd_r            <= {WD_W{1'b0}};
         tx_frame_r      <= 48'h0000_0000_0000;
         tx_idx_r        <= 3'd0;
         frame_cnt_r     <= 16'd0;
      end else begin
         phase_r         <= phase_nxt_s;
         avm_address_r   <= avm_address_nxt_s;
         avm_read_r      <= avm_read_nxt_s;
         avm_write_r     <= avm_write_nxt_s;
         avm_writedata_r <= avm_writedata_nxt_s;
         sw_valid_r      <= sw_valid_nxt_s;
         sw_res_ready_r  <= sw_res_ready_nxt_s;
         ref_seq_r       <= ref_seq_nxt_s;
         read_seq_r      <= read_seq_nxt_s;
         ref_len_r       <= ref_len_nxt_s;
         read_len_r      <= read_len_nxt_s;
         ref_len_pend_r  <= ref_len_pend_nxt_s;
         ref_rem_r       <= ref_rem_nxt_s;
         read_rem_r      <= read_rem_nxt_s;
         wd_r            <= wd_nxt_s;
         tx_frame_r      <= tx_frame_nxt_s;
         tx_idx_r        <= tx_idx_nxt_s;
         frame_cnt_r     <= frame_cnt_nxt_s;
      end
   end

   assign bus.avm_address   = avm_address_r;
   assign bus.avm_read      = avm_read_r;
   assign bus.avm_write     = avm_write_r;
   assign bus.avm_writedata = avm_writedata_r;
   assign bus.sw_valid      = sw_valid_r;
   assign bus.sw_res_ready  = sw_res_ready_r;
   assign bus.sw_ref_seq    = ref_seq_r;
   assign bus.sw_read_seq   = read_seq_r;
   assign bus.sw_ref_len    = ref_len_r;
   assign bus.sw_read_len   = read_len_r;
   assign frame_cnt         = frame_cnt_r;
endmodule
